// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Accepts one 23-bit instruction word per valid/ready handshake,
//               latches it, and walks the execution states for its class.
//               Presents the state code and latched word to the output
//               decoder, and drives PC step, completion, illegal-class and
//               retired-instruction status.
// Revision    : 1.0  initial release
// ============================================================================
module instr_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [22:0]      instr,
    output logic             instr_ready,
    output logic [4:0]       state,
    output logic [22:0]      opcode,
    output logic             alu_sub,
    output logic             PC_step,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    // State codes seen by the output decoder
    localparam logic [4:0] c_idle    = 5'b00000;
    localparam logic [4:0] c_load    = 5'b00001;
    localparam logic [4:0] c_mov     = 5'b00010;
    localparam logic [4:0] c_arith_a = 5'b00011;
    localparam logic [4:0] c_arith_g = 5'b00100;
    localparam logic [4:0] c_arith_w = 5'b00101;
    localparam logic [4:0] c_illegal = 5'b11111;

    // Instruction classes in instr[22:20]
    localparam logic [2:0] c_cls_load = 3'b000;
    localparam logic [2:0] c_cls_mov  = 3'b001;
    localparam logic [2:0] c_cls_add  = 3'b010;
    localparam logic [2:0] c_cls_sub  = 3'b011;

    logic [4:0]       r_state;
    logic [22:0]      r_opcode;
    logic             r_alu_sub;
    logic             r_pc_step;
    logic             r_done;
    logic             r_illegal;
    logic [CNT_W-1:0] r_retired;

    // Sequencer: the status pulses are computed alongside the next state so
    // each one is a flop output that is high only in its owning state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_idle;
            r_opcode  <= 23'd0;
            r_alu_sub <= 1'b0;
            r_pc_step <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            r_alu_sub <= 1'b0;
            r_pc_step <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            // done is a single-cycle pulse, so adding it counts each retirement once
            r_retired <= r_retired + {{(CNT_W-1){1'b0}}, r_done};

            case (r_state)
                c_idle: begin
                    if (instr_valid) begin
                        r_opcode <= instr;
                        case (instr[22:20])
                            c_cls_load: begin
                                r_state   <= c_load;
                                r_done    <= 1'b1;
                                r_pc_step <= 1'b1;
                            end
                            c_cls_mov: begin
                                r_state   <= c_mov;
                                r_done    <= 1'b1;
                                r_pc_step <= 1'b1;
                            end
                            c_cls_add, c_cls_sub: begin
                                r_state <= c_arith_a;
                            end
                            default: begin
                                r_state   <= c_illegal;
                                r_illegal <= 1'b1;
                                r_pc_step <= 1'b1;
                            end
                        endcase
                    end
                end
                c_arith_a: begin
                    r_state   <= c_arith_g;
                    // class bit 0 distinguishes sub from add
                    r_alu_sub <= r_opcode[20];
                end
                c_arith_g: begin
                    r_state   <= c_arith_w;
                    r_done    <= 1'b1;
                    r_pc_step <= 1'b1;
                end
                default: begin
                    // load, mov, arith_w and illegal all return to idle
                    r_state <= c_idle;
                end
            endcase
        end
    end

    // Ready depends only on the registered state, never on instr_valid
    assign instr_ready = (r_state == c_idle);

    assign state   = r_state;
    assign opcode  = r_opcode;
    assign alu_sub = r_alu_sub;
    assign PC_step = r_pc_step;
    assign done    = r_done;
    assign illegal = r_illegal;
    assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Directed self-checking bench for instr_sequencer (CNT_W=4).
//               Expected per-cycle outputs are queued as stimulus is driven
//               and popped for comparison after the clock edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_instr_sequencer;

    localparam int CNT_W = 4;

    localparam logic [4:0] c_idle    = 5'b00000;
    localparam logic [4:0] c_load    = 5'b00001;
    localparam logic [4:0] c_mov     = 5'b00010;
    localparam logic [4:0] c_arith_a = 5'b00011;
    localparam logic [4:0] c_arith_g = 5'b00100;
    localparam logic [4:0] c_arith_w = 5'b00101;
    localparam logic [4:0] c_illegal = 5'b11111;

    localparam logic [22:0] c_w_load = 23'h01A000;
    localparam logic [22:0] c_w_sub  = 23'h321000;
    localparam logic [22:0] c_w_add  = 23'h254000;
    localparam logic [22:0] c_w_mov  = 23'h123000;
    localparam logic [22:0] c_w_ill  = 23'h5AB000;

    logic             clk;
    logic             rst;
    logic             instr_valid;
    logic [22:0]      instr;
    logic             instr_ready;
    logic [4:0]       state;
    logic [22:0]      opcode;
    logic             alu_sub;
    logic             PC_step;
    logic             done;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    typedef struct packed {
        logic [4:0]       st;
        logic [22:0]      op;
        logic             rdy;
        logic             sub;
        logic             pcs;
        logic             dn;
        logic             ill;
        logic [CNT_W-1:0] ret;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad   = 0;

    instr_sequencer #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_ready(instr_ready),
        .state      (state),
        .opcode     (opcode),
        .alu_sub    (alu_sub),
        .PC_step    (PC_step),
        .done       (done),
        .illegal    (illegal),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [4:0] st, input logic [22:0] op,
                                input logic sub, input logic pcs, input logic dn,
                                input logic ill, input int ret);
        exp_t e;
        e.st  = st;
        e.op  = op;
        e.rdy = (st == c_idle);
        e.sub = sub;
        e.pcs = pcs;
        e.dn  = dn;
        e.ill = ill;
        e.ret = CNT_W'(ret);
        return e;
    endfunction

    // Drive one cycle of stimulus, queue what the DUT must show after the
    // edge, then pop and compare once the edge has passed.
    task automatic tick(input string tag, input logic v, input logic [22:0] w, input exp_t e);
        exp_t  got;
        string t;
        instr_valid = v;
        instr       = w;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        t   = tag_q.pop_front();
        chk({t, ".state"},   32'(state),       32'(got.st));
        chk({t, ".opcode"},  32'(opcode),      32'(got.op));
        chk({t, ".ready"},   32'(instr_ready), 32'(got.rdy));
        chk({t, ".alu_sub"}, 32'(alu_sub),     32'(got.sub));
        chk({t, ".PC_step"}, 32'(PC_step),     32'(got.pcs));
        chk({t, ".done"},    32'(done),        32'(got.dn));
        chk({t, ".illegal"}, 32'(illegal),     32'(got.ill));
        chk({t, ".retired"}, 32'(retired),     32'(got.ret));
    endtask

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 23'd0;
        #1;
        chk("rst_async.state", 32'(state), 32'(c_idle));
        repeat (2) @(posedge clk);
        #1;
        chk("rst.state",   32'(state),       32'(c_idle));
        chk("rst.opcode",  32'(opcode),      32'd0);
        chk("rst.retired", 32'(retired),     32'd0);
        chk("rst.ready",   32'(instr_ready), 32'd1);
        chk("rst.pulses",  32'({alu_sub, PC_step, done, illegal}), 32'd0);
        rst = 1'b0;

        // Idle with no valid: nothing moves
        for (int i = 0; i < 5; i++)
            tick("idle", 1'b0, 23'h7FFFFF, mk(c_idle, 23'd0, 0, 0, 0, 0, 0));

        // Load
        tick("load",      1'b1, c_w_load, mk(c_load, c_w_load, 0, 1, 1, 0, 0));
        tick("load_idle", 1'b0, 23'd0,    mk(c_idle, c_w_load, 0, 0, 0, 0, 1));

        // Sub, with a word offered while busy that must not be latched
        tick("sub_a",    1'b1, c_w_sub, mk(c_arith_a, c_w_sub, 0, 0, 0, 0, 1));
        tick("sub_g",    1'b1, c_w_mov, mk(c_arith_g, c_w_sub, 1, 0, 0, 0, 1));
        tick("sub_w",    1'b1, c_w_ill, mk(c_arith_w, c_w_sub, 0, 1, 1, 0, 1));
        tick("sub_idle", 1'b0, 23'd0,   mk(c_idle,    c_w_sub, 0, 0, 0, 0, 2));

        // Add: same sequence, subtract select stays low
        tick("add_a",    1'b1, c_w_add, mk(c_arith_a, c_w_add, 0, 0, 0, 0, 2));
        tick("add_g",    1'b0, 23'd0,   mk(c_arith_g, c_w_add, 0, 0, 0, 0, 2));
        tick("add_w",    1'b0, 23'd0,   mk(c_arith_w, c_w_add, 0, 1, 1, 0, 2));
        tick("add_idle", 1'b0, 23'd0,   mk(c_idle,    c_w_add, 0, 0, 0, 0, 3));

        // Illegal class: skipped, not retired
        tick("ill",      1'b1, c_w_ill, mk(c_illegal, c_w_ill, 0, 1, 0, 1, 3));
        tick("ill_idle", 1'b0, 23'd0,   mk(c_idle,    c_w_ill, 0, 0, 0, 0, 3));

        // Mov
        tick("mov",      1'b1, c_w_mov, mk(c_mov,  c_w_mov, 0, 1, 1, 0, 3));
        tick("mov_idle", 1'b0, 23'd0,   mk(c_idle, c_w_mov, 0, 0, 0, 0, 4));

        // Reset in the middle of a subtract
        tick("abort_a", 1'b1, c_w_sub, mk(c_arith_a, c_w_sub, 0, 0, 0, 0, 4));
        tick("abort_g", 1'b0, 23'd0,   mk(c_arith_g, c_w_sub, 1, 0, 0, 0, 4));
        #2;
        rst = 1'b1;
        #1;
        chk("abort.state",   32'(state),       32'(c_idle));
        chk("abort.pulses",  32'({alu_sub, PC_step, done, illegal}), 32'd0);
        chk("abort.retired", 32'(retired),     32'd0);
        chk("abort.opcode",  32'(opcode),      32'd0);
        chk("abort.ready",   32'(instr_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++)
            tick("post_abort", 1'b0, 23'd0, mk(c_idle, 23'd0, 0, 0, 0, 0, 0));

        // Back-to-back loads with valid held high; counter wraps past 15
        for (int k = 0; k < 17; k++) begin
            tick("wrap_load", 1'b1, c_w_load, mk(c_load, c_w_load, 0, 1, 1, 0, k));
            tick("wrap_idle", 1'b1, c_w_load, mk(c_idle, c_w_load, 0, 0, 0, 0, k + 1));
        end
        instr_valid = 1'b0;
        chk("wrap.final_retired", 32'(retired), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
